mca_sched: RTL and testbench
============================

MCA_SCHED -- requirements
Module: mca_sched

Interface
- REQ-001 Parameter NUM_CH, default 4, number of requesters sharing one mca_add_sub instance (2..8).
- REQ-002 Parameter WIDTH_COEFFICIENT, default 32, result width.
- REQ-003 Parameter NUM_ADDITIONS, default 16, operands per accumulation (1..16).
- REQ-004 clk  input  1  single clock; all state on rising edge.
- REQ-005 resetn  input  1  reset, asynchronous, active-low.
- REQ-006 stall  input  1  global hold; 1 freezes scheduler and accumulator.
- REQ-007 req  input  NUM_CH  per-channel level request for one accumulation.
- REQ-008 grant  output  NUM_CH  one-hot owner of accumulator; requester holds operands stable while granted.
- REQ-009 sel  output  $clog2(NUM_CH)  binary index of granted channel, drives external operand/S_values mux.
- REQ-010 mca_start  output  1  start pulse to accumulator.
- REQ-011 mca_enable  output  1  enable to accumulator, equals ~stall.
- REQ-012 mca_res  input  WIDTH_COEFFICIENT signed  accumulator result.
- REQ-013 res_out  output  WIDTH_COEFFICIENT signed  captured result.
- REQ-014 res_ch  output  $clog2(NUM_CH)  channel owning res_out.
- REQ-015 res_valid  output  1  one-cycle pulse, res_out/res_ch valid.
- REQ-016 ack  output  NUM_CH  one-cycle pulse to the served channel, same cycle as res_valid.

Function
- REQ-017 States: SCH_IDLE, SCH_ISSUE, SCH_WAIT, SCH_CAPTURE; all transitions and counters gated by ~stall.
- REQ-018 SCH_IDLE: if any req bit set, arbiter picks a winner, grant/sel register it, next SCH_ISSUE; else stay.
- REQ-019 SCH_ISSUE: mca_start=1 for exactly this one cycle, wait counter cleared, next SCH_WAIT.
- REQ-020 SCH_WAIT: 5-bit counter increments per enabled cycle; after 16 enabled cycles (counter==15) next SCH_CAPTURE, independent of NUM_ADDITIONS.
- REQ-021 SCH_CAPTURE: res_out<=mca_res, res_ch<=sel, res_valid and ack[sel] pulse next cycle, grant cleared, next SCH_IDLE.
- REQ-022 Latency: req seen in SCH_IDLE -> res_valid 19 enabled cycles later; back-to-back throughput one result per 19 enabled cycles.
- REQ-023 grant and sel stable from SCH_ISSUE through SCH_CAPTURE; no re-arbitration mid-operation.
- REQ-024 req dropped while granted: operation completes, result and ack still delivered.
- REQ-025 Winner's req still high at completion: re-eligible, subject to arbitration policy (REQ-030).
- REQ-026 stall high: state, counter, grant, outputs hold; res_valid/ack not re-pulsed; mca_start held high only if stall arrives in SCH_ISSUE (accumulator ignores it while disabled).
- REQ-027 res_out/res_ch hold last value until next capture.

Reset
- REQ-028 resetn low, any time including mid-operation: state SCH_IDLE, counter 0, grant 0, sel 0, mca_start 0, res_out 0, res_ch 0, res_valid 0, ack 0, RR pointer 0; accumulator shares resetn so both restart aligned; in-flight result discarded, no ack.

Configuration
- REQ-029 Macro MCA_SCHED_RR_EN selects arbitration policy.
- REQ-030 Defined: round-robin; pointer advances to channel after last winner on each capture; search starts at pointer. Undefined: fixed priority, lowest index wins, no pointer register.

Structure
- REQ-031 FIR_pkg holds sched_state_e enum and MCA_LATENCY=16 constant; scheduler uses MCA_LATENCY, no literal 16.
- REQ-032 One sub-module mca_rr_arb (combinational request/pointer -> one-hot winner); fixed-priority path implemented inside it under the macro.

Verification
- REQ-033 Single req[2] pulse held 1 cycle -> grant=0100, mca_start one cycle, res_valid 19 cycles later, res_ch=2, ack=0100, res_out equals golden add/sub of 16 operands.
- REQ-034 req=1111 continuous, RR build -> service order 0,1,2,3,0; fixed-priority build -> channel 0 every time.
- REQ-035 stall high 5 cycles in SCH_WAIT at counter 7 -> res_valid delayed exactly 5 cycles, res_out unchanged vs. unstalled run.
- REQ-036 resetn low at counter 10 of channel 1 -> all outputs 0 next cycle, no ack; subsequent req[3] served correctly from SCH_IDLE.
- REQ-037 req[1] dropped after SCH_ISSUE -> ack[1] and res_valid still asserted once; next arbitration excludes channel 1.
- REQ-038 Assertions: grant one-hot or zero; mca_start only in SCH_ISSUE; res_valid never two consecutive cycles.

Source files
------------

// File: rtl/FIR_pkg.sv
// Shared state encoding and accumulator timing for the mca_sched scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sched_state_e (scheduler FSM states), MCA_LATENCY (enabled cycles
// one accumulation needs), WAIT_CNT_W (width of the wait counter).
package FIR_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE    = 2'd0,
    SCH_ISSUE   = 2'd1,
    SCH_WAIT    = 2'd2,
    SCH_CAPTURE = 2'd3
  } sched_state_e;

  // The shared accumulator needs this many enabled cycles after its start
  // pulse, regardless of how many operands a channel actually supplies.
  localparam int MCA_LATENCY = 16;
  localparam int WAIT_CNT_W  = 5;

endpackage

// File: rtl/mca_rr_arb.sv
// Picks one requester among NUM_CH as a one-hot winner for the shared accumulator.
// Latency: purely combinational, winner valid in the same cycle as req.
// Backpressure: none; the caller decides when the winner is consumed.
// Ports: req (per-channel requests), ptr (round-robin start index, only with
//   MCA_SCHED_RR_EN defined), win (one-hot winner, zero when no request).
// Macro MCA_SCHED_RR_EN: defined -> round-robin from ptr, undefined -> lowest index wins.
module mca_rr_arb #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
`ifdef MCA_SCHED_RR_EN
  input  logic [$clog2(NUM_CH)-1:0] ptr,
`endif
  output logic [NUM_CH-1:0]         win
);

`ifdef MCA_SCHED_RR_EN
  logic [NUM_CH-1:0] hi_mask;
  logic [NUM_CH-1:0] req_hi;
  logic [NUM_CH-1:0] pick_src;

  // Requests at or above the pointer take precedence; if there are none the
  // search wraps to the full vector. x & -x isolates the lowest set bit, so no
  // variable indexing is needed.
  always_comb begin
    hi_mask  = ~((NUM_CH'(1) << ptr) - NUM_CH'(1));
    req_hi   = req & hi_mask;
    pick_src = (|req_hi) ? req_hi : req;
    win      = pick_src & (~pick_src + NUM_CH'(1));
  end
`else
  always_comb begin
    win = req & (~req + NUM_CH'(1));
  end
`endif

endmodule

// File: rtl/mca_sched.sv
// Time-shares one mca_add_sub accumulator between NUM_CH requesters.
// Latency: req seen in SCH_IDLE -> res_valid/ack 19 enabled cycles later; one result per 19 cycles.
// Backpressure: stall=1 freezes state, counter, grant and outputs; mca_enable drops with it.
// Ports: clk, resetn (async active-low); stall; req[NUM_CH] (level requests);
//   grant[NUM_CH]/sel (current owner, one-hot and binary); mca_start/mca_enable
//   (accumulator control); mca_res (accumulator result); res_out/res_ch/res_valid
//   (captured result); ack[NUM_CH] (pulse to served channel).
// Macro MCA_SCHED_RR_EN: defined -> round-robin arbitration, undefined -> fixed priority.
module mca_sched
  import FIR_pkg::*;
#(
  parameter int NUM_CH            = 4,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int NUM_ADDITIONS     = 16
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                stall,
  input  logic [NUM_CH-1:0]                   req,
  output logic [NUM_CH-1:0]                   grant,
  output logic [$clog2(NUM_CH)-1:0]           sel,
  output logic                                mca_start,
  output logic                                mca_enable,
  input  logic signed [WIDTH_COEFFICIENT-1:0] mca_res,
  output logic signed [WIDTH_COEFFICIENT-1:0] res_out,
  output logic [$clog2(NUM_CH)-1:0]           res_ch,
  output logic                                res_valid,
  output logic [NUM_CH-1:0]                   ack
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(MCA_LATENCY - 1);

  // The wait window is fixed at MCA_LATENCY, so more operands than that
  // could never be summed in time.
  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("mca_sched: NUM_CH must be 2..8");
  end
  if (NUM_ADDITIONS < 1 || NUM_ADDITIONS > MCA_LATENCY) begin : g_bad_num_add
    $error("mca_sched: NUM_ADDITIONS must be 1..MCA_LATENCY");
  end

  sched_state_e          state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [NUM_CH-1:0]     win;
  logic [SEL_W-1:0]      win_idx;

`ifdef MCA_SCHED_RR_EN
  logic [SEL_W-1:0]      rr_ptr;

  mca_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .win (win)
  );
`else
  mca_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req (req),
    .win (win)
  );
`endif

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win[i]) win_idx = SEL_W'(i);
    end
  end

  assign mca_enable = ~stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= SCH_IDLE;
    else         state <= state_nxt;
  end

  // mca_start follows the state alone, so a stall landing in SCH_ISSUE keeps
  // it high; the accumulator ignores it while mca_enable is low.
  always_comb begin
    state_nxt = state;
    mca_start = 1'b0;
    case (state)
      SCH_IDLE:    if (!stall && |req) state_nxt = SCH_ISSUE;
      SCH_ISSUE: begin
        mca_start = 1'b1;
        if (!stall) state_nxt = SCH_WAIT;
      end
      SCH_WAIT:    if (!stall && cnt == CNT_LAST) state_nxt = SCH_CAPTURE;
      SCH_CAPTURE: if (!stall) state_nxt = SCH_IDLE;
      default:     state_nxt = SCH_IDLE;
    endcase
  end

  // res_valid/ack clear every cycle, so a stall right after capture cannot
  // stretch or repeat the pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      grant     <= '0;
      sel       <= '0;
      res_out   <= '0;
      res_ch    <= '0;
      res_valid <= 1'b0;
      ack       <= '0;
    end else begin
      res_valid <= 1'b0;
      ack       <= '0;
      if (!stall) begin
        case (state)
          SCH_IDLE: begin
            if (|req) begin
              grant <= win;
              sel   <= win_idx;
            end
          end
          SCH_ISSUE: cnt <= '0;
          SCH_WAIT:  cnt <= cnt + WAIT_CNT_W'(1);
          SCH_CAPTURE: begin
            res_out   <= mca_res;
            res_ch    <= sel;
            res_valid <= 1'b1;
            ack       <= grant;
            grant     <= '0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MCA_SCHED_RR_EN
  // Next search starts just past the channel that was served.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (!stall && state == SCH_CAPTURE) begin
      rr_ptr <= (sel == SEL_W'(NUM_CH - 1)) ? '0 : sel + SEL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mca_sched.sv
module tb_mca_sched;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NA = 16;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 stall;
  logic [N-1:0]         req;
  logic [N-1:0]         grant;
  logic [1:0]           sel;
  logic                 mca_start;
  logic                 mca_enable;
  logic signed [W-1:0]  mca_res;
  logic signed [W-1:0]  res_out;
  logic [1:0]           res_ch;
  logic                 res_valid;
  logic [N-1:0]         ack;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  mca_sched #(.NUM_CH(N), .WIDTH_COEFFICIENT(W), .NUM_ADDITIONS(NA)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .stall      (stall),
    .req        (req),
    .grant      (grant),
    .sel        (sel),
    .mca_start  (mca_start),
    .mca_enable (mca_enable),
    .mca_res    (mca_res),
    .res_out    (res_out),
    .res_ch     (res_ch),
    .res_valid  (res_valid),
    .ack        (ack)
  );

  // Per-channel operand tables and add/sub selects, muxed by sel as the
  // external operand mux would be.
  logic signed [W-1:0] ops [N][NA];
  logic                sgn [N][NA];

  // Stand-in accumulator: clears on start, then folds one operand per enabled cycle.
  logic signed [W-1:0] acc;
  int                  acc_idx;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      acc_idx <= 0;
    end else if (mca_enable) begin
      if (mca_start) begin
        acc     <= '0;
        acc_idx <= 0;
      end else if (acc_idx < NA) begin
        acc     <= sgn[sel][acc_idx] ? acc - ops[sel][acc_idx] : acc + ops[sel][acc_idx];
        acc_idx <= acc_idx + 1;
      end
    end
  end
  assign mca_res = acc;

  // Continuous protocol checks.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL grant_onehot: grant=%b is not one-hot or zero", grant);
      end
      checks++;
      if (prev_valid && res_valid) begin
        errors++;
        $display("FAIL valid_pulse: res_valid high two cycles in a row, required single pulse");
      end
      checks++;
      if (mca_start && grant == '0) begin
        errors++;
        $display("FAIL start_owner: mca_start=1 with grant=%b, required an owner", grant);
      end
      prev_valid = res_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [W-1:0] golden(int ch);
    logic signed [W-1:0] s;
    s = '0;
    for (int i = 0; i < NA; i++) s = sgn[ch][i] ? s - ops[ch][i] : s + ops[ch][i];
    return s;
  endfunction

  function automatic int model_pick(logic [N-1:0] r);
`ifdef MCA_SCHED_RR_EN
    for (int k = 0; k < N; k++) if (r[(model_ptr + k) % N]) return (model_ptr + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  task automatic model_served(int ch);
    model_ptr = (ch + 1) % N;
  endtask

  task automatic new_ops();
    for (int c = 0; c < N; c++)
      for (int i = 0; i < NA; i++) begin
        ops[c][i] = $urandom;
        sgn[c][i] = 1'($urandom_range(0, 1));
      end
  endtask

  task automatic do_reset();
    req    = '0;
    stall  = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_ptr = 0;
  endtask

  // Steps edges until res_valid is seen; n counts the edges taken.
  task automatic wait_result(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!res_valid && n < limit);
  endtask

  task automatic test_reset();
    req    = '0;
    stall  = 1'b0;
    resetn = 1'b0;
    #12;
    checks++;
    if (grant !== '0 || sel !== '0 || mca_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: grant=%b sel=%0d start=%b, required 0", grant, sel, mca_start);
    end
    checks++;
    if (res_out !== '0 || res_ch !== '0 || res_valid !== 1'b0 || ack !== '0) begin
      errors++;
      $display("FAIL reset_res: res_out=%0d res_ch=%0d valid=%b ack=%b, required 0", res_out, res_ch, res_valid, ack);
    end
    checks++;
    if (mca_enable !== 1'b1) begin
      errors++;
      $display("FAIL reset_enable: mca_enable=%b, required 1", mca_enable);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_single();
    int n, starts;
    logic signed [W-1:0] exp;
    new_ops();
    exp = golden(2);
    @(posedge clk); #1 req = 4'b0100;
    @(posedge clk); #1 req = '0;
    n = 1;
    checks++;
    if (grant !== 4'b0100 || sel !== 2'd2) begin
      errors++;
      $display("FAIL single_grant: grant=%b sel=%0d, required 0100 sel=2", grant, sel);
    end
    starts = 0;
    while (!res_valid && n < 40) begin
      if (mca_start) starts++;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (starts != 1) begin
      errors++;
      $display("FAIL single_start: mca_start cycles=%0d, required 1", starts);
    end
    checks++;
    if (n != 19) begin
      errors++;
      $display("FAIL single_latency: %0d cycles, required 19", n);
    end
    checks++;
    if (res_ch !== 2'd2 || ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack: res_ch=%0d ack=%b, required 2 and 0100", res_ch, ack);
    end
    checks++;
    if (res_out !== exp) begin
      errors++;
      $display("FAIL single_result: res_out=%0d, required %0d", res_out, exp);
    end
    model_served(2);
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || ack !== '0 || res_out !== exp) begin
      errors++;
      $display("FAIL single_pulse: valid=%b ack=%b res_out=%0d, required 0, 0000, %0d", res_valid, ack, res_out, exp);
    end
  endtask

  task automatic test_back_to_back();
    int n, ch;
    logic [N-1:0] one;
    one = 1;
    do_reset();
    new_ops();
    @(posedge clk); #1 req = '1;
    for (int k = 0; k < 5; k++) begin
      ch = model_pick(req);
      wait_result(40, n);
      if (k == 4) req = '0;
      checks++;
      if (n != 19 || res_ch !== 2'(ch) || ack !== (one << ch)) begin
        errors++;
        $display("FAIL b2b_order[%0d]: cycles=%0d res_ch=%0d ack=%b, required 19, %0d, %b", k, n, res_ch, ack, ch, one << ch);
      end
      checks++;
      if (res_out !== golden(ch)) begin
        errors++;
        $display("FAIL b2b_result[%0d]: res_out=%0d, required %0d", k, res_out, golden(ch));
      end
      model_served(ch);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int n;
    new_ops();
    @(posedge clk); #1 req = 4'b0001;
    @(posedge clk); #1 req = '0;
    n = 1;
    while (n < 9) begin @(posedge clk); #1; n++; end
    stall = 1'b1;
    #1;
    checks++;
    if (mca_enable !== 1'b0) begin
      errors++;
      $display("FAIL stall_enable: mca_enable=%b, required 0", mca_enable);
    end
    repeat (5) begin @(posedge clk); #1; n++; end
    checks++;
    if (grant !== 4'b0001 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: grant=%b valid=%b, required 0001 and 0", grant, res_valid);
    end
    stall = 1'b0;
    while (!res_valid && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 24) begin
      errors++;
      $display("FAIL stall_latency: %0d cycles, required 24", n);
    end
    checks++;
    if (res_out !== golden(0) || res_ch !== 2'd0) begin
      errors++;
      $display("FAIL stall_result: res_out=%0d ch=%0d, required %0d ch=0", res_out, res_ch, golden(0));
    end
    model_served(0);
  endtask

  task automatic test_stall_issue();
    int n;
    logic signed [W-1:0] exp;
    new_ops();
    exp = golden(3);
    @(posedge clk); #1 req = 4'b1000;
    @(posedge clk); #1 req = '0;
    n = 1;
    stall = 1'b1;
    repeat (3) begin @(posedge clk); #1; n++; end
    checks++;
    if (mca_start !== 1'b1 || grant !== 4'b1000) begin
      errors++;
      $display("FAIL issue_stall: start=%b grant=%b, required 1 and 1000", mca_start, grant);
    end
    stall = 1'b0;
    while (!res_valid && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 22 || res_out !== exp) begin
      errors++;
      $display("FAIL issue_latency: cycles=%0d res_out=%0d, required 22 and %0d", n, res_out, exp);
    end
    stall = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || ack !== '0 || res_out !== exp) begin
      errors++;
      $display("FAIL capture_stall: valid=%b ack=%b res_out=%0d, required 0, 0000, %0d", res_valid, ack, res_out, exp);
    end
    stall = 1'b0;
    model_served(3);
  endtask

  task automatic test_reset_mid();
    int n, pulses;
    new_ops();
    @(posedge clk); #1 req = 4'b0010;
    @(posedge clk); #1;
    n = 1;
    while (n < 12) begin @(posedge clk); #1; n++; end
    resetn = 1'b0;
    req = '0;
    #1;
    checks++;
    if (grant !== '0 || sel !== '0 || mca_start !== 1'b0 || res_out !== '0 || res_ch !== '0 ||
        res_valid !== 1'b0 || ack !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: grant=%b sel=%0d start=%b res_out=%0d ch=%0d valid=%b ack=%b, required all 0",
               grant, sel, mca_start, res_out, res_ch, res_valid, ack);
    end
    @(posedge clk); #1 resetn = 1'b1;
    model_ptr = 0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (res_valid || ack != '0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midreset_noack: %0d result cycles after reset, required 0", pulses);
    end
    req = 4'b1000;
    wait_result(40, n);
    req = '0;
    checks++;
    if (n != 19 || res_ch !== 2'd3 || ack !== 4'b1000 || res_out !== golden(3)) begin
      errors++;
      $display("FAIL midreset_next: cycles=%0d ch=%0d ack=%b res_out=%0d, required 19, 3, 1000, %0d",
               n, res_ch, ack, res_out, golden(3));
    end
    model_served(3);
    @(posedge clk); #1;
  endtask

  task automatic test_drop();
    int n, pulses, ch;
    logic [N-1:0] one;
    one = 1;
    new_ops();
    @(posedge clk); #1 req = 4'b0010;
    @(posedge clk); #1;
    n = 1;
    @(posedge clk); #1;
    n++;
    req = 4'b1100;
    pulses = 0;
    while (n < 19) begin
      @(posedge clk); #1; n++;
      if (res_valid) pulses++;
    end
    checks++;
    if (pulses != 1 || res_valid !== 1'b1 || ack !== 4'b0010 || res_ch !== 2'd1) begin
      errors++;
      $display("FAIL drop_ack: pulses=%0d valid=%b ack=%b ch=%0d, required 1, 1, 0010, 1", pulses, res_valid, ack, res_ch);
    end
    checks++;
    if (res_out !== golden(1)) begin
      errors++;
      $display("FAIL drop_result: res_out=%0d, required %0d", res_out, golden(1));
    end
    model_served(1);
    ch = model_pick(req);
    wait_result(40, n);
    req = '0;
    checks++;
    if (n != 19 || res_ch !== 2'(ch) || ack !== (one << ch) || res_out !== golden(ch)) begin
      errors++;
      $display("FAIL drop_next: cycles=%0d ch=%0d ack=%b res_out=%0d, required 19, %0d, %b, %0d",
               n, res_ch, ack, res_out, ch, one << ch, golden(ch));
    end
    model_served(ch);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    req    = '0;
    stall  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_stall_issue();
    test_reset_mid();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
